alu_share_ctrl: RTL
===================

Name: alu_share_ctrl

Overview:
- Shares the single-cycle 16-bit ALU between two requesters: port 0 (decode/execute) and port 1 (auxiliary/microcode).
- Arbitrates round-robin and drives the ALU operands and opcode.
- Captures each result in a one-entry response register with a requester tag.
- Owns the architectural Z/V/N flag register, updated per opcode.

Parameters:
- DW, 16, operand/result width
- OPW, 3, ALU opcode width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0_valid  in  1  port 0 request
- req0_ready  out  1  port 0 request accepted this cycle
- req0_op  in  OPW  port 0 opcode
- req0_a  in  DW  port 0 operand 1
- req0_b  in  DW  port 0 operand 2
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same directions and widths as port 0, for port 1
- alu_in1  out  DW  to ALU operand 1
- alu_in2  out  DW  to ALU operand 2
- alu_op  out  OPW  to ALU opcode
- alu_out  in  DW  ALU result (combinational)
- alu_flags  in  3  ALU flags [2]=Z [1]=V [0]=N
- alu_error  in  1  ALU overflow
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the held result
- rsp_data  out  DW  held result
- rsp_error  out  1  overflow for the held result
- flags_q  out  3  architectural flags [2]=Z [1]=V [0]=N

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_error=0.
  - flags_q=3'b000.
  - Round-robin pointer last=1, so port 0 wins first.
- Response-register states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
- can_accept = EMPTY, or (FULL and rsp_ready).
- Grant (combinational):
  - If can_accept=0: no grant.
  - If only one port is valid: grant that port.
  - If both ports are valid: grant the port != last.
- reqN_ready = can_accept & grant==N. Ready may depend combinationally on valid; requesters must not make valid depend on ready.
- ALU drive: alu_in1/alu_in2/alu_op = granted port's a/b/op. With no grant, drive port 0's fields (don't-care).
- Accept edge (a grant exists and can_accept):
  - rsp_data <= alu_out; rsp_id <= grant; rsp_valid <= 1; last <= grant.
  - rsp_error <= alu_error when op is 000 or 001, else 0.
- Drain without accept (FULL, rsp_ready=1, no grant): rsp_valid <= 0. rsp_data and rsp_id hold their stale values.
- Simultaneous drain and accept: the register reloads, rsp_valid stays 1, and there is no bubble.
- FULL and rsp_ready=0: both readies are 0; response and flags hold.
- Latency: result visible on rsp_* one cycle after the accept edge.
- Throughput: 1 op/cycle when rsp_ready is held high.
- Flag update happens on the accept edge only. Bits not listed keep their value:
  - 000 ADD, 001 SUB: Z, V, N <= alu_flags[2:0].
  - 010 XOR, 100 SLL, 101 SRA, 110 ROR: Z <= alu_flags[2].
  - 011 RED, 111 PADDSUB: no flag change.
- The ALU's flag bits outside that mask are undefined and must never reach flags_q.
- Reset mid-operation: the pending response is discarded, flags clear, and last returns to 1. A request held across reset release is re-arbitrated normally.
- Fairness: with both ports continuously valid and rsp_ready=1, grants alternate 0,1,0,1. No port waits more than one accepted op.

Test Plan:
- Port 0 ADD, a=16'h7FFF, b=16'h0001, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_data=16'h8000, rsp_error=1, flags_q=3'b011.
- After the ADD, port 1 XOR, a=b=16'h00FF -> rsp_data=0, rsp_id=1, rsp_error=0, flags_q=3'b111 (Z set, V/N retained). A following RED leaves flags_q=3'b111.
- Both ports valid for 4 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1 and both readies pulse alternately.
- Port 0 SUB 5-5 accepted, rsp_ready=0 for 3 cycles with port 1 valid -> req1_ready=0 throughout; rsp_data=0 and flags_q Z=1 are stable. Raising rsp_ready gives a same-cycle accept of port 1 with rsp_valid staying 1.
- rst_n low asynchronously while FULL with flags_q=3'b011 -> rsp_valid=0 and flags_q=0 immediately, without waiting for a clock edge. After release, with both ports valid, port 0 is granted first.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin share of one single-cycle ALU between two requesters, with a
// one-entry tagged response register and the architectural Z/V/N flags.
module alu_share_ctrl #(
  parameter int DW  = 16,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [OPW-1:0] req0_op,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [OPW-1:0] req1_op,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out,
  input  logic [2:0]     alu_flags,
  input  logic           alu_error,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [DW-1:0]  rsp_data,
  output logic           rsp_error,
  output logic [2:0]     flags_q
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB = OPW'(1);
  localparam logic [OPW-1:0] OP_XOR = OPW'(2);
  localparam logic [OPW-1:0] OP_SLL = OPW'(4);
  localparam logic [OPW-1:0] OP_SRA = OPW'(5);
  localparam logic [OPW-1:0] OP_ROR = OPW'(6);

  typedef enum logic {EMPTY, FULL} rsp_state_e;

  rsp_state_e state_q, state_d;
  logic       last_q;
  logic       gnt, can_accept, accept, sel1;
  logic       arith_op, zonly_op;

  always_comb begin
    gnt = 1'b0;
    if (req0_valid && req1_valid) gnt = ~last_q;
    else                          gnt = req1_valid;
    can_accept = (state_q == EMPTY) || rsp_ready;
    accept     = can_accept && (req0_valid || req1_valid);
    req0_ready = accept && !gnt;
    req1_ready = accept && gnt;
  end

  // Without a grant the ALU simply sees port 0; its result is ignored then.
  assign sel1    = accept && gnt;
  assign alu_in1 = sel1 ? req1_a  : req0_a;
  assign alu_in2 = sel1 ? req1_b  : req0_b;
  assign alu_op  = sel1 ? req1_op : req0_op;

  assign arith_op = (alu_op == OP_ADD) || (alu_op == OP_SUB);
  assign zonly_op = (alu_op == OP_XOR) || (alu_op == OP_SLL) ||
                    (alu_op == OP_SRA) || (alu_op == OP_ROR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (accept) state_d = FULL;
               else if (rsp_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  assign rsp_valid = (state_q == FULL);

  // Flag bits the opcode does not define are masked off here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
      flags_q   <= 3'b000;
      last_q    <= 1'b1;
    end else if (accept) begin
      rsp_id    <= gnt;
      rsp_data  <= alu_out;
      rsp_error <= arith_op ? alu_error : 1'b0;
      last_q    <= gnt;
      if (arith_op)      flags_q    <= alu_flags;
      else if (zonly_op) flags_q[2] <= alu_flags[2];
    end
  end

endmodule
